// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - Groups REPEAT PUF evaluations per challenge and reports response instability.
// Optional wait-state watchdog enabled by defining PUF_SEQ_TIMEOUT_EN.
module puf_challenge_sequencer #(
    parameter int REPEAT      = 2,
    parameter int RESP_W      = 64,
    parameter int TIMEOUT_CYC = 1024,
    localparam int FW         = $clog2(RESP_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              request,
    input  logic              ready_challenge,
    input  logic [127:0]      challenge,
    output logic [127:0]      puf_chal,
    output logic              puf_start,
    input  logic              puf_done,
    input  logic [RESP_W-1:0] puf_resp,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [127:0]      res_chal,
    output logic [RESP_W-1:0] res_resp,
    output logic [FW-1:0]     res_flip_cnt,
    output logic [1:0]        res_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_PWAIT, S_REQ, S_WAITC, S_EVAL, S_WAITR, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_primed;
    logic [5:0]        r_iter;
    logic [RESP_W-1:0] r_flip_mask;
    logic [RESP_W-1:0] w_next_mask;
    logic [FW-1:0]     w_tmo_cnt;
    logic              w_last;
    logic              w_tmo;

    function automatic logic [FW-1:0] popcount(input logic [RESP_W-1:0] v);
        logic [FW-1:0] n;
        n = '0;
        for (int i = 0; i < RESP_W; i++) begin
            n = n + FW'(v[i]);
        end
        return n;
    endfunction

    assign w_next_mask = r_flip_mask | (res_resp ^ puf_resp);
    assign w_last      = (r_iter == 6'(REPEAT - 1));
    assign w_tmo_cnt   = (r_iter == 6'd0) ? '0 : popcount(r_flip_mask);

`ifdef PUF_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] r_tmo_cnt;
    logic          w_in_wait;
    logic          w_strobe;

    assign w_in_wait = (r_state == S_PWAIT) || (r_state == S_WAITC) || (r_state == S_WAITR);
    assign w_strobe  = ((r_state == S_PWAIT) || (r_state == S_WAITC)) ? ready_challenge
                     : (r_state == S_WAITR) ? puf_done : 1'b0;
    assign w_tmo     = w_in_wait && !w_strobe && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Every exit from a wait state clears the count, so each entry starts at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait && !w_strobe && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_primed     <= 1'b0;
            r_iter       <= '0;
            r_flip_mask  <= '0;
            busy         <= 1'b0;
            request      <= 1'b0;
            puf_start    <= 1'b0;
            puf_chal     <= '0;
            res_valid    <= 1'b0;
            res_chal     <= '0;
            res_resp     <= '0;
            res_flip_cnt <= '0;
            res_err      <= '0;
        end else begin
            request   <= 1'b0;
            puf_start <= 1'b0;
            if (w_tmo) begin
                r_state      <= S_DONE;
                r_primed     <= 1'b0;
                res_valid    <= 1'b1;
                res_err[1]   <= 1'b1;
                res_flip_cnt <= w_tmo_cnt;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        busy    <= 1'b1;
                        request <= 1'b1;
                        r_state <= r_primed ? S_REQ : S_PRIME;
                    end
                    S_PRIME: r_state <= S_PWAIT;
                    S_PWAIT: if (ready_challenge) begin
                        r_primed <= 1'b1;
                        request  <= 1'b1;
                        r_state  <= S_REQ;
                    end
                    S_REQ: r_state <= S_WAITC;
                    S_WAITC: if (ready_challenge) begin
                        puf_chal  <= challenge;
                        puf_start <= 1'b1;
                        r_state   <= S_EVAL;
                    end
                    S_EVAL: r_state <= S_WAITR;
                    S_WAITR: if (puf_done) begin
                        r_iter <= r_iter + 6'd1;
                        if (r_iter == 6'd0) begin
                            res_chal    <= puf_chal;
                            res_resp    <= puf_resp;
                            res_err     <= '0;
                            r_flip_mask <= '0;
                        end else begin
                            if (puf_chal != res_chal) begin
                                res_err[0] <= 1'b1;
                            end
                            r_flip_mask <= w_next_mask;
                        end
                        if (w_last) begin
                            res_valid    <= 1'b1;
                            res_flip_cnt <= popcount(w_next_mask);
                            r_state      <= S_DONE;
                        end else begin
                            request <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                    S_DONE: if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_iter    <= '0;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Consumer-side controller for the PUF challenge generator. It issues request pulses to the generator, captures each `challenge` on `ready_challenge`, drives the PUF core once per captured challenge, and compares the repeated responses. Each group yields one result record: challenge, reference response, unstable-bit count and error flags. It sits between the challenge generator and the PUF key/ID logic, on the same clock.

## Interface
- `REPEAT`, 2: evaluations per group; must equal the generator's repeat count; range 2..63.
- `RESP_W`, 64: PUF response width.
- `TIMEOUT_CYC`, 1024: wait limit in cycles; used only with `PUF_SEQ_TIMEOUT_EN`.
- `FW`, `$clog2(RESP_W+1)`: derived flip-count width; not overridable.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: begin one group; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `request` out 1: request to the generator; one-cycle pulse.
- `ready_challenge` in 1: generator challenge-valid strobe.
- `challenge` in 128: generator challenge.
- `puf_chal` out 128: challenge presented to the PUF core.
- `puf_start` out 1: one-cycle PUF evaluation start.
- `puf_done` in 1: PUF response-valid strobe.
- `puf_resp` in RESP_W: PUF response.
- `res_valid` out 1: result record available.
- `res_ready` in 1: result accepted.
- `res_chal` out 128: group challenge.
- `res_resp` out RESP_W: reference (first) response.
- `res_flip_cnt` out FW: number of unstable response bits.
- `res_err` out 2: [0] challenge mismatch within the group; [1] timeout.

## Operation
- States and transitions:
  - IDLE: on `start`, go to PRIME if `primed`=0, else go to REQ.
  - PRIME: `request`=1 for one cycle, then go to PWAIT.
  - PWAIT: on `ready_challenge`, discard the challenge, set `primed`=1, go to REQ.
  - REQ: `request`=1 for one cycle, then go to WAITC.
  - WAITC: on `ready_challenge`, latch `challenge` into `puf_chal`, go to EVAL.
  - EVAL: `puf_start`=1 for one cycle, then go to WAITR.
  - WAITR: on `puf_done`, capture the response and increment `iter`. Go to DONE if `iter`=REPEAT, else go to REQ.
  - DONE: `res_valid`=1; on `res_ready`, go to IDLE.
- Priming: the generator advances its seed on the REPEAT-th request. One discarded request after reset aligns groups, so every group sees REPEAT identical challenges.
- Iteration 0 stores the reference challenge in `res_chal` and the reference response in `res_resp`. It also clears the mismatch flag and `flip_mask`.
- Iterations 1..REPEAT-1:
  - Set `res_err[0]` if the latched challenge differs from `res_chal`.
  - Update `flip_mask |= res_resp ^ puf_resp`.
- `res_flip_cnt` = popcount(`flip_mask`). It is registered on entry to DONE and is 0..RESP_W.
- `puf_chal` is held stable from latch until the next WAITC capture.
- Result outputs hold stable while `res_valid`=1. They are cleared only by reset or by the next group's iteration 0.
- Ignored inputs:
  - `start` when not in IDLE.
  - `ready_challenge` outside WAITC and PWAIT.
  - `puf_done` outside WAITR.
  - `res_ready` outside DONE.
- Simultaneous `ready_challenge` and `puf_done` is handled per the current state only.
- Reset mid-operation:
  - FSM returns to IDLE; `primed`=0, `iter`=0.
  - All outputs go to 0, including the `res_*` fields.
  - The next group re-primes.

## Timing
- Reset value of every output is 0.
- `request` is high exactly one cycle, then low at least until the next REQ/PRIME. This guarantees the rising edge the generator detects.
- With the generator, `ready_challenge` arrives 2 cycles after the `request` cycle.
- Latency per iteration, excluding PUF time: REQ(1) + WAITC(≥2) + EVAL(1) + WAITR(≥1).
- `res_valid` rises the cycle after the last `puf_done` is sampled. It falls the cycle after `res_ready` is sampled high in DONE.
- `busy` falls in the same cycle that `res_valid` falls.

## Configuration
- `PUF_SEQ_TIMEOUT_EN` defined:
  - A counter runs in PWAIT, WAITC and WAITR and resets on each state entry.
  - If it reaches TIMEOUT_CYC-1 without the awaited strobe, the FSM goes to DONE with `res_err[1]`=1.
  - `res_flip_cnt` reflects iterations completed so far.
  - `primed` is cleared, so the next group re-primes.
- Not defined: no counter; wait states wait indefinitely; `res_err[1]` is tied 0.

## Test plan
- Prime plus stable response: reset, `start`, generator model seed 128'hC9F99D6C9F99D6C9F99D6C9F99D6C9F, PUF returns 64'hA5A5_5A5A_0F0F_F0F0 twice.
  - Expect 3 `request` pulses.
  - Expect `res_chal` = model S1, `res_flip_cnt`=0, `res_err`=0.
- Unstable bits: second response = first ^ 64'h0000_0000_0000_000F → `res_flip_cnt`=4, `res_resp` = first response.
- Back-to-back groups: second `start` issues exactly 2 requests, with no prime → `res_chal` = S2.
- Mismatch: bench generator returns differing challenges within a group → `res_err[0]`=1.
- Backpressure and ignored inputs:
  - Hold `res_ready`=0 for 20 cycles → outputs stable, `busy`=1.
  - Spurious `start`, `puf_done` and `ready_challenge` during this window are ignored.
- Timeout (macro on, TIMEOUT_CYC=16), PUF never completes:
  - `res_valid` after 16 cycles in WAITR, `res_err`=2'b10.
  - Also drive `rst`=0 mid-WAITC → all outputs 0 next cycle, next group re-primes.
